// File: rtl/aes128_key_schedule.sv
// Iterative AES-128 key expansion: one round key per valid/ready handshake,
// using an external pipelined S-box fed with RotWord(w3).
`timescale 1ns/1ps
module aes128_key_schedule #(
  parameter int unsigned SBOX_LAT = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic         busy_o,
  output logic [31:0]  sbox_in_o,
  input  logic [31:0]  sbox_out_i
);

  typedef logic [7:0] bv8_t;
  typedef bv8_t [3:0] word_t;
  typedef enum logic [1:0] {ST_IDLE, ST_OUT, ST_SBOX} state_t;

  localparam int unsigned CW        = $clog2(SBOX_LAT + 1);
  localparam bv8_t        RCON_INIT = 8'h01;
  localparam logic [3:0]  LAST_RND  = 4'd10;

  state_t         r_state;
  state_t         w_state_nxt;
  word_t          r_w0, r_w1, r_w2, r_w3;
  logic [3:0]     r_rnd;
  bv8_t           r_rcon;
  logic [CW-1:0]  r_cnt;

  word_t          w_t, w_n0, w_n1, w_n2, w_n3;
  bv8_t           w_rcon_nxt;
  logic           w_sbox_done;

  // K is frozen for the whole SBOX wait, so the S-box result is stable once it arrives
  assign w_sbox_done = (r_cnt == CW'(SBOX_LAT));
  assign w_t         = sbox_out_i ^ {r_rcon, 24'h000000};
  assign w_n0        = r_w0 ^ w_t;
  assign w_n1        = r_w1 ^ w_n0;
  assign w_n2        = r_w2 ^ w_n1;
  assign w_n3        = r_w3 ^ w_n2;
  assign w_rcon_nxt  = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  assign rk_o       = {r_w0, r_w1, r_w2, r_w3};
  assign rk_idx_o   = r_rnd;
  assign rk_valid_o = (r_state == ST_OUT);
  assign busy_o     = (r_state != ST_IDLE);
  assign sbox_in_o  = {r_w3[2:0], r_w3[3]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start_i) w_state_nxt = ST_OUT;
      ST_OUT:  if (rk_ready_i) w_state_nxt = (r_rnd == LAST_RND) ? ST_IDLE : ST_SBOX;
      ST_SBOX: if (w_sbox_done) w_state_nxt = ST_OUT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_w0   <= '0;
      r_w1   <= '0;
      r_w2   <= '0;
      r_w3   <= '0;
      r_rnd  <= '0;
      r_rcon <= RCON_INIT;
      r_cnt  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            {r_w0, r_w1, r_w2, r_w3} <= key_i;
            r_rnd  <= '0;
            r_rcon <= RCON_INIT;
          end
        end
        ST_OUT: begin
          if (rk_ready_i && (r_rnd != LAST_RND)) r_cnt <= '0;
        end
        ST_SBOX: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_sbox_done) begin
            r_w0   <= w_n0;
            r_w1   <= w_n1;
            r_w2   <= w_n2;
            r_w3   <= w_n3;
            r_rnd  <= r_rnd + 4'd1;
            r_rcon <= w_rcon_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_key_schedule.sv
// Bench for aes128_key_schedule: three instances (S-box latency 3, 1, 5) each
// driving its own pipelined S-box model; round keys checked against a scoreboard.
`timescale 1ns/1ps
module tb_aes128_key_schedule;

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [79:0] RCON_T = 80'h01020408102040801b36;

  localparam logic [127:0] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    int           idx;
    logic [127:0] rk;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst     [3];
  logic         start   [3];
  logic [127:0] key_in  [3];
  logic         rdy     [3];
  logic [127:0] rk      [3];
  logic [3:0]   idx     [3];
  logic         valid   [3];
  logic         busy    [3];
  logic [31:0]  sbox_in [3];

  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           hs_count = 0;
  int           last_hs_idx = -1;
  int           hs10_cyc = -1000;
  int           b2b_gap = 0;
  bit           rmode = 1'b0;
  bit           ok;
  sb_t          sb_q [$];
  logic [127:0] cap_keys [11];
  vec_t         vecs [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sb(input logic [7:0] x);
    int p;
    p = 2047 - 8 * int'(x);
    return SBOX_T[p -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  function automatic logic [31:0] rot(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 3 : (g == 1) ? 1 : 5;
  endfunction

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", nm);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 3 : (g == 1) ? 1 : 5;
    logic [31:0] pipe [LAT];

    always @(posedge clk) begin
      pipe[0] <= subw(sbox_in[g]);
      for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end

    aes128_key_schedule #(.SBOX_LAT(LAT)) u_dut (
      .clk_i      (clk),
      .rst_i      (rst[g]),
      .start_i    (start[g]),
      .key_i      (key_in[g]),
      .rk_o       (rk[g]),
      .rk_idx_o   (idx[g]),
      .rk_valid_o (valid[g]),
      .rk_ready_i (rdy[g]),
      .busy_o     (busy[g]),
      .sbox_in_o  (sbox_in[g]),
      .sbox_out_i (pipe[LAT-1])
    );
  end

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) rdy[i] = rmode ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Monitor: per-instance history for stall stability, spacing and the scoreboard pop
  bit           prv_valid [3];
  bit           prv_stall [3];
  bit           chk_idle  [3];
  logic [127:0] prv_rk    [3];
  logic [3:0]   prv_idx   [3];
  logic [31:0]  held_w3   [3];
  int           last_rise [3];

  always @(negedge clk) begin
    sb_t e;
    for (int g = 0; g < 3; g++) begin
      if (rst[g]) begin
        prv_valid[g] = 1'b0;
        prv_stall[g] = 1'b0;
        chk_idle[g]  = 1'b0;
      end else begin
        if (prv_stall[g]) begin
          chk("stall_valid", 128'(valid[g]), 128'(1));
          chk("stall_rk", rk[g], prv_rk[g]);
          chk("stall_idx", 128'(idx[g]), 128'(prv_idx[g]));
        end
        if (chk_idle[g]) begin
          chk("idle_busy", 128'(busy[g]), 128'(0));
          chk("idle_valid", 128'(valid[g]), 128'(0));
          chk_idle[g] = 1'b0;
        end
        if (valid[g]) begin
          chk("sbox_in_out", 128'(sbox_in[g]), 128'(rot(rk[g][31:0])));
          held_w3[g] = rk[g][31:0];
          if (!prv_valid[g]) begin
            if (idx[g] != 4'd0 && !rmode)
              chk("spacing", 128'(cyc - last_rise[g]), 128'(lat_of(g) + 2));
            if (idx[g] == 4'd0) b2b_gap = cyc - hs10_cyc;
            last_rise[g] = cyc;
          end
        end else if (busy[g]) begin
          chk("sbox_in_wait", 128'(sbox_in[g]), 128'(rot(held_w3[g])));
        end
        if (valid[g] && rdy[g]) begin
          if (sb_q.size() == 0) begin
            timeout("unexpected_key");
          end else begin
            e = sb_q.pop_front();
            chk("hs_idx", 128'(idx[g]), 128'(e.idx));
            chk("hs_rk", rk[g], e.rk);
          end
          if (idx[g] <= 4'd10) cap_keys[idx[g]] = rk[g];
          hs_count++;
          last_hs_idx = int'(idx[g]);
          if (idx[g] == 4'd10) begin
            hs10_cyc    = cyc;
            chk_idle[g] = 1'b1;
          end
        end
        prv_valid[g] = valid[g];
        prv_stall[g] = valid[g] && !rdy[g];
        prv_rk[g]    = rk[g];
        prv_idx[g]   = idx[g];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subw(rot(t)) ^ {RCON_T[79-8*(i/4-1) -: 8], 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      sb_q.push_back('{idx: r, rk: {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}});
  endtask

  task automatic start_exp(input int g, input logic [127:0] k);
    push_model(k);
    for (int i = 0; i < 11; i++) cap_keys[i] = '0;
    last_hs_idx = -1;
    start[g]  = 1'b1;
    key_in[g] = k;
    tick();
    start[g]  = 1'b0;
    key_in[g] = {4{$urandom()}};
    @(negedge clk);
    chk("start_valid", 128'(valid[g]), 128'(1));
    chk("start_idx", 128'(idx[g]), 128'(0));
  endtask

  task automatic wait_done(input int g);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      done = (sb_q.size() == 0) && !busy[g];
    end
    if (!done) timeout("wait_done");
  endtask

  task automatic wait_sbox_after(input int hs_idx);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      tick();
      ok = (last_hs_idx == hs_idx) && !valid[0] && busy[0];
    end
    if (!ok) timeout("wait_sbox");
  endtask

  initial begin
    int base;
    vecs[0] = '{key: K1, idx: 0,  exp: K1};
    vecs[1] = '{key: K1, idx: 1,  exp: K1_1};
    vecs[2] = '{key: K1, idx: 10, exp: K1_10};
    vecs[3] = '{key: K2, idx: 0,  exp: K2};
    vecs[4] = '{key: K2, idx: 10, exp: K2_10};

    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; key_in[g] = '0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int g = 0; g < 3; g++) begin
      chk("rst_valid", 128'(valid[g]), 128'(0));
      chk("rst_busy", 128'(busy[g]), 128'(0));
      chk("rst_rk", rk[g], 128'(0));
      chk("rst_idx", 128'(idx[g]), 128'(0));
      chk("rst_sbox_in", 128'(sbox_in[g]), 128'(0));
      rst[g] = 1'b0;
    end
    tick();

    for (int v = 0; v < 5; v++) begin
      start_exp(0, vecs[v].key);
      wait_done(0);
      chk($sformatf("vec%0d_idx%0d", v, vecs[v].idx), cap_keys[vecs[v].idx], vecs[v].exp);
    end

    rmode = 1'b1;
    start_exp(0, K1);
    wait_done(0);
    rmode = 1'b0;
    chk("bp_idx1", cap_keys[1], K1_1);
    chk("bp_idx10", cap_keys[10], K1_10);

    start_exp(0, K1);
    wait_sbox_after(4);
    start[0]  = 1'b1;
    key_in[0] = K2;
    tick();
    start[0]  = 1'b0;
    wait_done(0);
    chk("busy_start_idx10", cap_keys[10], K1_10);
    start_exp(0, K2);
    wait_done(0);
    chk("after_idle_idx10", cap_keys[10], K2_10);

    start_exp(0, K1);
    wait_sbox_after(5);
    rst[0] = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(valid[0]), 128'(0));
    chk("mid_rst_busy", 128'(busy[0]), 128'(0));
    chk("mid_rst_rk", rk[0], 128'(0));
    chk("mid_rst_idx", 128'(idx[0]), 128'(0));
    chk("mid_rst_sbox_in", 128'(sbox_in[0]), 128'(0));
    sb_q.delete();
    tick();
    rst[0] = 1'b0;
    repeat (3) begin
      tick();
      chk("no_partial", 128'(valid[0]), 128'(0));
    end
    start_exp(0, K2);
    wait_done(0);
    chk("rst_restart_idx10", cap_keys[10], K2_10);

    for (int g = 1; g < 3; g++) begin
      start_exp(g, K1);
      wait_done(g);
      chk($sformatf("lat%0d_idx1", lat_of(g)), cap_keys[1], K1_1);
      chk($sformatf("lat%0d_idx10", lat_of(g)), cap_keys[10], K1_10);
    end

    push_model(K1);
    push_model(K1);
    base      = hs_count;
    start[0]  = 1'b1;
    key_in[0] = K1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      ok = (hs_count >= base + 12);
    end
    if (!ok) timeout("b2b_second_start");
    start[0] = 1'b0;
    wait_done(0);
    chk("b2b_gap", 128'(b2b_gap), 128'(2));
    chk("b2b_count", 128'(hs_count - base), 128'(22));

    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
